sequence_serializer: RTL and testbench
======================================

// Module: sequence_serializer
// PURPOSE
//  Upstream feeder for the Moore "1011" sequence detector. Accepts parallel words over a
//  valid/ready handshake, buffers them in a small FIFO and shifts them out one bit per
//  clock on serial_out. serial_out drives the detector's sequence_in directly.
//  Words are emitted back-to-back with no gap bits. This lets benches and upstream logic
//  inject multi-word bit streams, including patterns that overlap word boundaries.
// PARAMETERS
//  WIDTH      4  bits per word (>=2)
//  DEPTH      2  FIFO entries (power of 2, >=2)
//  LSB_FIRST  0  0: shift MSB first; 1: shift LSB first
//  IDLE_BIT   0  value held on serial_out when no word is being shifted
// PORTS
//  clock         in   1      rising-edge clock, sole clock domain
//  reset         in   1      synchronous, active-high; flushes FIFO and FSM
//  word_in       in   WIDTH  parallel word to serialize
//  word_valid    in   1      word_in is valid this cycle
//  word_ready    out  1      FIFO can accept; transfer on word_valid & word_ready at clock edge
//  serial_out    out  1      registered serial bit (to detector sequence_in)
//  serial_valid  out  1      serial_out carries a data bit this cycle
//  busy          out  1      shifting or FIFO non-empty
// BEHAVIOUR
//  - Reset (sync, high), values after the reset edge:
//    serial_out=IDLE_BIT, serial_valid=0, busy=0, word_ready=1.
//    FIFO pointers and count=0, bit counter=0, FSM=IDLE.
//  - word_ready = !fifo_full (combinational from count).
//    A push while full is ignored; the word is not lost because ready=0 and the source must hold it.
//  - FSM IDLE: if FIFO non-empty, pop the head into the shift register, set bit_cnt=0 -> SHIFT.
//  - FSM SHIFT: each cycle, present the next bit and increment bit_cnt.
//    At bit_cnt==WIDTH-1, if FIFO non-empty, pop and reload (stay SHIFT, bit_cnt=0); else -> IDLE.
//  - Latency: word accepted at edge N with FIFO empty and FSM IDLE.
//    The popped head is loaded at edge N+1; bit 0 appears on serial_out after edge N+2.
//    Word k+1's first bit follows word k's last bit in the very next cycle (zero gap).
//  - Bit order: bit index WIDTH-1 first unless LSB_FIRST=1.
//  - serial_valid=1 exactly for cycles where serial_out is a data bit.
//    Otherwise serial_out=IDLE_BIT and serial_valid=0.
//  - Push and pop in the same cycle: count unchanged, both pointers advance (wrap mod DEPTH).
//    Push into a full FIFO is not allowed even if a pop occurs that cycle (no pass-through).
//  - Pointer wrap: log2(DEPTH)-bit pointers, natural wrap; count is log2(DEPTH)+1 bits.
//  - Reset mid-word: the partial word is abandoned and FIFO contents discarded.
//    serial_out=IDLE_BIT from the cycle after the reset edge.
//  - busy = (state==SHIFT) | (count!=0).
// STRUCTURE
//  - Package seq_pkg: FSM state encoding (S_IDLE, S_SHIFT) and default WIDTH=4.
//    The detector testbench also uses PATTERN=4'b1011 from this package.
//  - Sub-module seq_word_fifo: synchronous FIFO (WIDTH, DEPTH) exposing push, pop,
//    rd_data, full, empty and count.
//  - Top: FSM, bit counter, shift register and output registers.
// TESTING
//  1. Reset 3 cycles, push 4'b1011 once -> serial_out 1,0,1,1 on 4 consecutive cycles,
//     serial_valid high for exactly those 4 cycles; detector_out=1 in the cycle after the 4th bit.
//  2. Push 4'b1011 then 4'b0110 back-to-back -> stream 1011_0110 with no gap bit;
//     detector hits once per 1011 occurrence in the stream.
//  3. DEPTH=2, hold word_valid=1 with 4 words -> word_ready drops after 2 entries + 1 shifting;
//     the 4th word is accepted only after the next pop; all 16 bits appear in order.
//  4. Assert reset at the 2nd bit of 4'b1011 with one word queued -> serial_out=0 and
//     serial_valid=0 next cycle, busy=0, queued word never emitted.
//  5. LSB_FIRST=1, push 4'b1101 -> serial_out 1,0,1,1.
//  6. No pushes for 20 cycles after reset -> serial_out=IDLE_BIT, serial_valid=0,
//     word_ready=1 and busy=0 throughout.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence serializer and the "1011" detector.
//   state_e    : serializer FSM encoding (S_IDLE, S_SHIFT)
//   DEF_WIDTH  : default word width for the serializer
//   PATTERN    : bit pattern recognised by the downstream detector
package seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int          DEF_WIDTH = 4;
  localparam logic [3:0]  PATTERN   = 4'b1011;

endpackage

// File: rtl/seq_word_fifo.sv
// Synchronous word FIFO feeding the serializer shift register.
//   clock, reset : rising-edge clock, synchronous active-high flush
//   push/wr_data : write request and data; ignored while full
//   pop/rd_data  : read request; rd_data always shows the head entry
//   full/empty   : status flags derived from count
//   count        : number of stored words (0..DEPTH)
module seq_word_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even when a pop happens the same
  // cycle: no pass-through, the source simply holds the word.
  assign push_ok = push & ~full;
  assign pop_ok  = pop  & ~empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers guard every
  // read, so stale contents are never observed and the array can map to
  // plain registers or RAM without a reset network.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sequence_serializer.sv
// Parallel-to-serial feeder for the "1011" sequence detector.
//   clock        : rising-edge clock, sole domain
//   reset        : synchronous active-high; abandons the current word, flushes FIFO
//   word_in      : parallel word, accepted on word_valid & word_ready
//   word_valid   : word_in valid this cycle
//   word_ready   : FIFO not full
//   serial_out   : registered serial bit (IDLE_BIT when not shifting)
//   serial_valid : serial_out carries a data bit
//   busy         : shifting or FIFO non-empty
// Words leave back-to-back with no gap bits so patterns may straddle words.
module sequence_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   DEPTH     = 2,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic                   serial_out_q, serial_out_d;
  logic                   serial_valid_q, serial_valid_d;

  logic                   fifo_pop;
  logic [WIDTH-1:0]       fifo_rd_data;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  seq_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (word_valid),
    .wr_data (word_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign word_ready   = ~fifo_full;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign busy         = (state_q == S_SHIFT) | (fifo_count != '0);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    serial_out_d   = IDLE_BIT;
    serial_valid_d = 1'b0;
    fifo_pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // The outgoing bit always sits at the shift register's leading end,
        // so bit order is fixed by the shift direction alone.
        serial_valid_d = 1'b1;
        if (LSB_FIRST != 0) begin
          serial_out_d = shift_q[0];
          shift_d      = shift_q >> 1;
        end else begin
          serial_out_d = shift_q[WIDTH-1];
          shift_d      = shift_q << 1;
        end
        bit_cnt_d = bit_cnt_q + CW'(1);

        if (bit_cnt_q == CW'(WIDTH-1)) begin
          bit_cnt_d = '0;
          // Reloading on the last bit keeps consecutive words gap-free.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      serial_out_q   <= IDLE_BIT;
      serial_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
    end
  end

endmodule

// File: tb/tb_sequence_serializer.sv
// Self-checking bench for sequence_serializer. Two instances: an MSB-first
// one (dut_a) and an LSB-first one (dut_b). Expected bits are queued when a
// word is accepted and compared as serial bits appear.
module tb_sequence_serializer;
  import seq_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic [W-1:0] word_in_a = '0, word_in_b = '0;
  logic         word_valid_a = 1'b0, word_valid_b = 1'b0;
  logic         word_ready_a, word_ready_b;
  logic         serial_out_a, serial_out_b;
  logic         serial_valid_a, serial_valid_b;
  logic         busy_a, busy_b;

  always #5 clock = ~clock;

  sequence_serializer #(.WIDTH(W), .DEPTH(2), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .word_in      (word_in_a),
    .word_valid   (word_valid_a),
    .word_ready   (word_ready_a),
    .serial_out   (serial_out_a),
    .serial_valid (serial_valid_a),
    .busy         (busy_a)
  );

  sequence_serializer #(.WIDTH(W), .DEPTH(2), .LSB_FIRST(1), .IDLE_BIT(1'b0)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .word_in      (word_in_b),
    .word_valid   (word_valid_b),
    .word_ready   (word_ready_b),
    .serial_out   (serial_out_b),
    .serial_valid (serial_valid_b),
    .busy         (busy_b)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic q_a[$];
  logic q_b[$];

  // Stream observers: pattern history, hit count and longest valid run.
  logic [3:0] hist_a = '0, hist_b = '0;
  int         hits_a = 0;
  int         run_a = 0, max_run_a = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offers a word until accepted (bounded); queues its bits in emission order.
  task automatic push(input bit sel_b, input logic [W-1:0] w, output int waits);
    logic rdy;
    bit   ok;
    waits = 0;
    ok    = 1'b0;
    if (sel_b) begin word_in_b = w; word_valid_b = 1'b1; end
    else       begin word_in_a = w; word_valid_a = 1'b1; end
    while (!ok && waits <= 50) begin
      rdy = sel_b ? word_ready_b : word_ready_a;
      @(posedge clock);
      #1;
      if (rdy) ok = 1'b1;
      else     waits++;
    end
    if (!ok) check("push_timeout", 32'(waits), 32'd0);
    else if (sel_b) for (int i = 0; i < W; i++)      q_b.push_back(w[i]);
    else            for (int i = W - 1; i >= 0; i--) q_a.push_back(w[i]);
    if (sel_b) word_valid_b = 1'b0;
    else       word_valid_a = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while ((busy_a || busy_b) && c < 200) begin
      step(1);
      c++;
    end
    step(2);
    check({tag, "_drain_a"}, 32'(q_a.size()), 32'd0);
    check({tag, "_drain_b"}, 32'(q_b.size()), 32'd0);
  endtask

  // Scoreboard: compare every data bit, and require IDLE_BIT otherwise.
  always @(negedge clock) begin
    if (!reset) begin
      if (serial_valid_a) begin
        check("a_bit_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) check("a_bit", 32'(serial_out_a), 32'(q_a.pop_front()));
        hist_a = {hist_a[2:0], serial_out_a};
        if (hist_a == PATTERN) hits_a++;
        run_a++;
        if (run_a > max_run_a) max_run_a = run_a;
      end else begin
        check("a_idle_out", 32'(serial_out_a), 32'd0);
        run_a = 0;
      end
      if (serial_valid_b) begin
        check("b_bit_expected", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) check("b_bit", 32'(serial_out_b), 32'(q_b.pop_front()));
        hist_b = {hist_b[2:0], serial_out_b};
      end else begin
        check("b_idle_out", 32'(serial_out_b), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         waits;
    logic [7:0] vld_trace;

    // Reset for 3 edges; check state held after the reset edges.
    reset = 1'b1;
    step(3);
    check("rst_serial_out",   32'(serial_out_a),   32'd0);
    check("rst_serial_valid", 32'(serial_valid_a), 32'd0);
    check("rst_busy",         32'(busy_a),         32'd0);
    check("rst_word_ready",   32'(word_ready_a),   32'd1);
    check("rst_busy_b",       32'(busy_b),         32'd0);
    reset = 1'b0;

    // Idle: 20 cycles with no pushes.
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_ready", 32'(word_ready_a), 32'd1);
      check("idle_busy",  32'(busy_a),       32'd0);
    end

    // Single word: latency two edges, four valid cycles, one detector hit.
    hist_a = '0; hits_a = 0;
    push(1'b0, 4'b1011, waits);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      vld_trace[7-i] = serial_valid_a;
    end
    check("t1_valid_trace", 32'(vld_trace), 32'b0011_1100);
    step(1);
    check("t1_hits", 32'(hits_a), 32'd1);

    // Back-to-back words: no gap, overlap across word boundary hits twice.
    hist_a = '0; hits_a = 0; max_run_a = 0;
    push(1'b0, 4'b1011, waits);
    push(1'b0, 4'b0110, waits);
    wait_drain("t2");
    check("t2_hits",    32'(hits_a),    32'd2);
    check("t2_max_run", 32'(max_run_a), 32'd8);

    // Backpressure: 2 queued + 1 shifting, fourth word waits for the pop.
    max_run_a = 0;
    push(1'b0, 4'b1011, waits);
    check("t3_w1_wait", 32'(waits), 32'd0);
    push(1'b0, 4'b0110, waits);
    check("t3_w2_wait", 32'(waits), 32'd0);
    push(1'b0, 4'b1110, waits);
    check("t3_w3_wait", 32'(waits), 32'd0);
    check("t3_full_ready", 32'(word_ready_a), 32'd0);
    check("t3_full_busy",  32'(busy_a),       32'd1);
    push(1'b0, 4'b0001, waits);
    check("t3_w4_wait", 32'(waits), 32'd3);
    wait_drain("t3");
    check("t3_max_run", 32'(max_run_a), 32'd16);

    // Reset during the 2nd bit with a word queued.
    push(1'b0, 4'b1011, waits);
    push(1'b0, 4'b0110, waits);
    step(2);
    check("t4_pre_valid", 32'(serial_valid_a), 32'd1);
    reset = 1'b1;
    step(1);
    check("t4_serial_out",   32'(serial_out_a),   32'd0);
    check("t4_serial_valid", 32'(serial_valid_a), 32'd0);
    check("t4_busy",         32'(busy_a),         32'd0);
    check("t4_word_ready",   32'(word_ready_a),   32'd1);
    q_a.delete();
    step(1);
    reset = 1'b0;
    step(10);
    check("t4_post_busy", 32'(busy_a), 32'd0);

    // LSB-first instance: 4'b1101 goes out as 1,0,1,1.
    hist_b = '0;
    push(1'b1, 4'b1101, waits);
    wait_drain("t5");
    check("t5_stream", 32'(hist_b), 32'b1011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
